act_func_ctrl: RTL

ACT_FUNC_CTRL -- requirements
Module: act_func_ctrl

---
 rtl/act_func_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/act_func_ctrl.sv
// Activation sequencer: streams len words from the input buffer through
// the activation datapath and into the output buffer.
// Ports: clk/reset; init,len,mode,rd_base,wr_base request; ready/done/err
// status; rd_en/rd_addr/rd_data read side; act_mode/act_in/act_out
// datapath; wr_en/wr_addr/wr_data write side.
module act_func_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W:0]   len,
  input  logic              mode,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              act_mode,
  output logic [WIDTH-1:0]  act_in,
  input  logic [WIDTH-1:0]  act_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              rd_vld;

  assign ready   = (state == IDLE);
  assign wr_data = act_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      rd_vld   <= 1'b0;
      act_mode <= 1'b0;
      act_in   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      // rd_vld marks the cycle the read data is on rd_data
      rd_vld <= rd_en;
      wr_en  <= rd_vld;
      if (rd_vld) begin
        act_in  <= rd_data;
        wr_addr <= wr_ptr;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (init) begin
            if (len == '0) begin
              done <= 1'b1;
            end else if (len > MAX_LEN) begin
              err <= 1'b1;
            end else begin
              state    <= RUN;
              act_mode <= mode;
              rd_en    <= 1'b1;
              rd_addr  <= rd_base;
              wr_ptr   <= wr_base;
              cnt      <= len - 1'b1;
            end
          end
        end
        RUN: begin
          if (cnt == '0) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            cnt     <= cnt - 1'b1;
          end
        end
        DRAIN: begin
          // last write is on the bus and nothing else is in flight
          if (wr_en && !rd_vld) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
